// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter that shares one register-interface target among
// NoPorts initiators. A granted request is forwarded in the same cycle.
// An initiator that is not accepted immediately keeps the grant until
// its transfer completes.

package reg_rr_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } rsp_t;

endpackage

module reg_rr_arbiter #(
    parameter int unsigned NoPorts  = 2,
    parameter type         req_t    = reg_rr_pkg::req_t,
    parameter type         rsp_t    = reg_rr_pkg::rsp_t,
    parameter int unsigned IdxWidth = (NoPorts > 1) ? $clog2(NoPorts) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  req_t                in_req_i [NoPorts],
    output rsp_t                in_rsp_o [NoPorts],
    output req_t                out_req_o,
    input  rsp_t                out_rsp_i,
    output logic [IdxWidth-1:0] gnt_idx_o
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t              state;
    logic [IdxWidth-1:0] rr_ptr;
    logic [IdxWidth-1:0] lock_idx;

    logic                found;
    logic [IdxWidth-1:0] sel;
    logic [IdxWidth-1:0] grant_idx;
    logic                forward;

    // Successor of a port index, wrapping at NoPorts-1 so that a
    // non-power-of-two port count never yields an out-of-range index.
    function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] idx);
        if (32'(idx) >= NoPorts - 32'd1) begin
            return '0;
        end
        return idx + IdxWidth'(1);
    endfunction

    // Find the first valid initiator, starting at rr_ptr and wrapping around.
    always_comb begin
        int unsigned         cand;
        logic [IdxWidth-1:0] cand_idx;
        found    = 1'b0;
        sel      = rr_ptr;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 0; i < NoPorts; i++) begin
            cand = 32'(rr_ptr) + i;
            if (cand >= NoPorts) begin
                cand = cand - NoPorts;
            end
            cand_idx = cand[IdxWidth-1:0];
            if (!found && in_req_i[cand_idx].valid) begin
                found = 1'b1;
                sel   = cand_idx;
            end
        end
    end

    // Route the locked or newly selected initiator to the target and the
    // target response back to it; everything reads as zero while in reset.
    always_comb begin
        out_req_o = '0;
        gnt_idx_o = '0;
        for (int unsigned k = 0; k < NoPorts; k++) begin
            in_rsp_o[k] = '0;
        end
        grant_idx = rr_ptr;
        forward   = 1'b0;
        if (state == LOCKED) begin
            grant_idx = lock_idx;
            forward   = 1'b1;
        end else if (found) begin
            grant_idx = sel;
            forward   = 1'b1;
        end
        if (rst_ni) begin
            gnt_idx_o = grant_idx;
            if (forward) begin
                out_req_o           = in_req_i[grant_idx];
                in_rsp_o[grant_idx] = out_rsp_i;
            end
        end
    end

    // Advance the round-robin pointer on completion, or hold the grant
    // for an initiator the target did not accept in its first cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        if (out_rsp_i.ready) begin
                            rr_ptr <= next_idx(sel);
                        end else begin
                            lock_idx <= sel;
                            state    <= LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (in_req_i[lock_idx].valid && out_rsp_i.ready) begin
                        rr_ptr <= next_idx(lock_idx);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A locked initiator must keep valid asserted until it is accepted.
    locked_valid_held: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (state == LOCKED) |-> in_req_i[lock_idx].valid
    );

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Directed bench for reg_rr_arbiter: a 4-port and a 3-port instance share
// one clock and one target response; expected grants are hand-derived.

module tb_reg_rr_arbiter;

    logic clk;
    logic rst4_n;
    logic rst3_n;

    reg_rr_pkg::req_t req4 [4];
    reg_rr_pkg::rsp_t rsp4 [4];
    reg_rr_pkg::req_t out_req4;
    logic [1:0]       gnt4;

    reg_rr_pkg::req_t req3 [3];
    reg_rr_pkg::rsp_t rsp3 [3];
    reg_rr_pkg::req_t out_req3;
    logic [1:0]       gnt3;

    reg_rr_pkg::rsp_t out_rsp;

    int total;
    int bad;

    reg_rr_arbiter #(
        .NoPorts (4)
    ) dut4 (
        .clk_i     (clk),
        .rst_ni    (rst4_n),
        .in_req_i  (req4),
        .in_rsp_o  (rsp4),
        .out_req_o (out_req4),
        .out_rsp_i (out_rsp),
        .gnt_idx_o (gnt4)
    );

    reg_rr_arbiter #(
        .NoPorts (3)
    ) dut3 (
        .clk_i     (clk),
        .rst_ni    (rst3_n),
        .in_req_i  (req3),
        .in_rsp_o  (rsp3),
        .out_req_o (out_req3),
        .out_rsp_i (out_rsp),
        .gnt_idx_o (gnt3)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] portAddr(input int p);
        return 32'((p + 1) * 256);
    endfunction

    // Count one comparison and report it if the values differ.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge and let it settle.
    task automatic applyStimulus(input logic [3:0] v4, input logic [2:0] v3,
                                 input logic ready, input logic [31:0] rdata);
        @(negedge clk);
        for (int p = 0; p < 4; p++) req4[p].valid = v4[p];
        for (int p = 0; p < 3; p++) req3[p].valid = v3[p];
        out_rsp.ready = ready;
        out_rsp.rdata = rdata;
        out_rsp.error = 1'b0;
        #1;
    endtask

    // Full-cycle reset of the 4-port instance with all requests dropped.
    task automatic resetFour();
        @(negedge clk);
        rst4_n = 1'b0;
        for (int p = 0; p < 4; p++) req4[p].valid = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst4_n = 1'b0;
        rst3_n = 1'b0;
        out_rsp = '0;
        for (int p = 0; p < 4; p++) begin
            req4[p].addr  = portAddr(p);
            req4[p].write = 1'b1;
            req4[p].wdata = 32'hA000 + 32'(p);
            req4[p].wstrb = 4'hF;
            req4[p].valid = 1'b0;
        end
        for (int p = 0; p < 3; p++) begin
            req3[p].addr  = portAddr(p);
            req3[p].write = 1'b0;
            req3[p].wdata = 32'hB000 + 32'(p);
            req3[p].wstrb = 4'h3;
            req3[p].valid = 1'b0;
        end

        // Outputs stay zero while reset is held, even with a valid request.
        applyStimulus(4'b0010, 3'b000, 1'b1, 32'hDEAD_0001);
        checkOutput("rst_valid", 64'(out_req4.valid), 64'd0);
        checkOutput("rst_addr",  64'(out_req4.addr),  64'd0);
        checkOutput("rst_gnt",   64'(gnt4),           64'd0);
        checkOutput("rst_rsp1",  64'(rsp4[1]),        64'd0);

        @(negedge clk);
        rst4_n = 1'b1;
        rst3_n = 1'b1;
        for (int p = 0; p < 4; p++) req4[p].valid = 1'b0;

        // Only port 2 valid, target ready: same-cycle forward, rr_ptr -> 3.
        applyStimulus(4'b0100, 3'b000, 1'b1, 32'hA1A1_0002);
        checkOutput("p2_gnt",   64'(gnt4),           64'd2);
        checkOutput("p2_addr",  64'(out_req4.addr),  64'(portAddr(2)));
        checkOutput("p2_ready", 64'(rsp4[2].ready),  64'd1);
        checkOutput("p2_rdata", 64'(rsp4[2].rdata),  64'hA1A1_0002);
        checkOutput("p0_idle",  64'(rsp4[0].ready),  64'd0);

        // rr_ptr = 3: ports 0 and 3 valid, target stalls -> lock on 3.
        applyStimulus(4'b1001, 3'b000, 1'b0, 32'hB1B1_0000);
        checkOutput("lk3_gnt",   64'(gnt4),          64'd3);
        checkOutput("lk3_addr",  64'(out_req4.addr), 64'(portAddr(3)));
        checkOutput("lk3_rd0",   64'(rsp4[0].rdata), 64'd0);

        // Locked: port 1 arrives but is ignored; completion wraps rr_ptr to 0.
        applyStimulus(4'b1011, 3'b000, 1'b1, 32'hC1C1_0000);
        checkOutput("lk3_hold",  64'(gnt4),          64'd3);
        checkOutput("lk3_rdy3",  64'(rsp4[3].ready), 64'd1);
        checkOutput("lk3_rdy1",  64'(rsp4[1].ready), 64'd0);
        checkOutput("lk3_rdy0",  64'(rsp4[0].ready), 64'd0);

        applyStimulus(4'b1001, 3'b000, 1'b1, 32'hD1D1_0000);
        checkOutput("wrap_gnt",  64'(gnt4),          64'd0);
        checkOutput("wrap_addr", 64'(out_req4.addr), 64'(portAddr(0)));

        // Ports 0 and 1 from reset; target stalls three cycles.
        resetFour();
        for (int c = 0; c < 3; c++) begin
            applyStimulus(4'b0011, 3'b000, 1'b0, 32'hE0E0_0000 + 32'(c));
            checkOutput($sformatf("stall%0d_gnt", c),  64'(gnt4),          64'd0);
            checkOutput($sformatf("stall%0d_addr", c), 64'(out_req4.addr), 64'(portAddr(0)));
            checkOutput($sformatf("stall%0d_rd0", c),  64'(rsp4[0].rdata), 64'hE0E0_0000 + 64'(c));
            checkOutput($sformatf("stall%0d_rd1", c),  64'(rsp4[1].rdata), 64'd0);
        end
        applyStimulus(4'b0011, 3'b000, 1'b1, 32'hE0E0_00FF);
        checkOutput("stall_done_gnt",  64'(gnt4),          64'd0);
        checkOutput("stall_done_rdy0", 64'(rsp4[0].ready), 64'd1);
        checkOutput("stall_done_rdy1", 64'(rsp4[1].ready), 64'd0);
        applyStimulus(4'b0011, 3'b000, 1'b1, 32'hE0E0_0100);
        checkOutput("next_gnt1", 64'(gnt4), 64'd1);

        // All four requesting, target always ready: strict rotation.
        resetFour();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(4'b1111, 3'b000, 1'b1, 32'h5000 + 32'(c));
            checkOutput($sformatf("rot%0d_gnt", c), 64'(gnt4), 64'(c % 4));
            for (int k = 0; k < 4; k++) begin
                checkOutput($sformatf("rot%0d_rd%0d", c, k), 64'(rsp4[k].rdata),
                            (k == c % 4) ? 64'h5000 + 64'(c) : 64'd0);
            end
        end

        // rr_ptr = 2 now; lock on port 1, then pulse reset between clock edges.
        applyStimulus(4'b0010, 3'b000, 1'b0, 32'h0);
        checkOutput("pre_rst_gnt", 64'(gnt4), 64'd1);
        @(negedge clk);
        rst4_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 64'(out_req4.valid), 64'd0);
        checkOutput("midrst_gnt",   64'(gnt4),           64'd0);
        #2;
        rst4_n = 1'b1;
        req4[3].valid = 1'b1;
        #1;
        checkOutput("postrst_gnt",  64'(gnt4),           64'd1);
        checkOutput("postrst_addr", 64'(out_req4.addr),  64'(portAddr(1)));
        applyStimulus(4'b1010, 3'b000, 1'b1, 32'h0);
        checkOutput("relock_gnt", 64'(gnt4), 64'd1);
        applyStimulus(4'b1010, 3'b000, 1'b1, 32'h0);
        checkOutput("after_gnt3", 64'(gnt4), 64'd3);

        // Three-port instance: reach rr_ptr = 2, then ports 2 and 0 alternate.
        applyStimulus(4'b0000, 3'b010, 1'b1, 32'h0);
        checkOutput("n3_gnt1", 64'(gnt3), 64'd1);
        applyStimulus(4'b0000, 3'b101, 1'b1, 32'h0);
        checkOutput("n3_gnt2",  64'(gnt3),          64'd2);
        checkOutput("n3_addr2", 64'(out_req3.addr), 64'(portAddr(2)));
        applyStimulus(4'b0000, 3'b101, 1'b1, 32'h0);
        checkOutput("n3_gnt0", 64'(gnt3), 64'd0);
        applyStimulus(4'b0000, 3'b101, 1'b1, 32'h0);
        checkOutput("n3_gnt2b", 64'(gnt3), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_rr_arbiter.md
Name: reg_rr_arbiter

Overview:
- Shares one register-interface target among NoPorts initiators using round-robin arbitration with per-transaction locking.
- Sits upstream of the register demultiplexer and register files. Multiple bus masters (cores, DMA, debug) reach one configuration space through it.
- Zero-latency forwarding: a granted request reaches the target in the same cycle.

Parameters:
- NoPorts, 2, number of initiator ports; must be >= 1.
- req_t, logic, register request struct with fields addr, write, wdata, wstrb, valid.
- rsp_t, logic, register response struct with fields rdata, error, ready.
- IdxWidth, (NoPorts > 1) ? $clog2(NoPorts) : 1, derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- in_req_i  in  NoPorts x req_t  initiator requests.
- in_rsp_o  out  NoPorts x rsp_t  initiator responses.
- out_req_o  out  req_t  request to the shared target.
- out_rsp_i  in  rsp_t  response from the shared target.
- gnt_idx_o  out  IdxWidth  index currently forwarded; valid when out_req_o.valid = 1.

Behaviour:
- Protocol: a transfer completes in the cycle where valid = 1 and ready = 1. Initiators hold valid and payload stable until ready.
- State: state (IDLE/LOCKED), rr_ptr (IdxWidth), lock_idx (IdxWidth).
- Reset values: state = IDLE, rr_ptr = 0, lock_idx = 0.
- Outputs while rst_ni = 0: out_req_o = '0, all in_rsp_o = '0, gnt_idx_o = 0.
- IDLE arbitration:
  - sel = first k with in_req_i[k].valid, searching rr_ptr, rr_ptr+1, …, NoPorts-1, 0, …, wrapping modulo NoPorts.
  - Combinationally: out_req_o = in_req_i[sel], in_rsp_o[sel] = out_rsp_i, gnt_idx_o = sel.
  - If out_rsp_i.ready is high the same cycle: the transfer completes, rr_ptr <= (sel+1) mod NoPorts, state stays IDLE.
  - Otherwise: lock_idx <= sel, state <= LOCKED.
  - No valid anywhere: out_req_o = '0, gnt_idx_o = rr_ptr, rr_ptr unchanged.
- LOCKED:
  - out_req_o = in_req_i[lock_idx] regardless of other requesters; in_rsp_o[lock_idx] = out_rsp_i; gnt_idx_o = lock_idx.
  - On in_req_i[lock_idx].valid && out_rsp_i.ready: rr_ptr <= (lock_idx+1) mod NoPorts, state <= IDLE.
  - If the locked initiator drops valid (protocol violation), stay LOCKED and forward valid = 0. A simulation-only assertion flags it.
- Non-selected ports always see in_rsp_o[k] = '0, so ready = 0, error = 0, rdata = 0.
- Back-to-back: the cycle after completion is IDLE, so a new arbitration happens with the updated rr_ptr. A one-cycle transfer every cycle is sustainable.
- Fairness: with all ports requesting continuously, grants cycle 0,1,…,NoPorts-1,0. No port waits more than NoPorts-1 completed transfers.
- Wrap: rr_ptr at NoPorts-1 advances to 0. With non-power-of-2 NoPorts, rr_ptr never holds a value >= NoPorts.
- Simultaneous events: a new valid on another port during LOCKED is ignored until unlock. The completion cycle's rr_ptr update takes effect for the next cycle's arbitration.
- Reset mid-transaction: state returns to IDLE immediately (async) and the locked transfer is abandoned. The target must tolerate the valid drop.
- NoPorts = 1: pure pass-through with the same lock logic; rr_ptr is constant 0.
- Paths: no combinational path from out_rsp_i.ready to out_req_o. The request path depends only on in_req_i and registered state.

Test Plan:
- NoPorts = 4, only port 2 valid, target ready same cycle → out_req_o.addr = port 2 addr in that cycle; gnt_idx_o = 2; in_rsp_o[2].ready = 1; rr_ptr becomes 3.
- Ports 0 and 1 valid from reset, target ready held low 3 cycles, then high → port 0 forwarded all 4 cycles; port 1 sees ready = 0 throughout; port 1 is granted on the following cycle.
- All 4 ports valid continuously, target always ready → grant sequence 0,1,2,3,0,1 over 6 cycles; each in_rsp_o[k].rdata matches the target rdata only in its grant cycle.
- Locked on port 3 with rr_ptr = 3, completion → rr_ptr wraps to 0; next grant goes to port 0 when ports 0 and 3 are both valid.
- NoPorts = 3, ports 2 and 0 valid with rr_ptr = 2 → grant 2 then 0, never an out-of-range index.
- rst_ni asserted while LOCKED on port 1 → out_req_o.valid = 0 immediately; after release with port 1 still valid, port 1 is re-granted with rr_ptr = 0 search order.
